// File: rtl/mem_stage.sv
// Memory stage: captures one execute-stage instruction at a time. ALU ops write back on the
// capture edge. Loads and stores issue a single memory request and stall upstream until the
// request is acknowledged. Also registers the branch redirect.
// Optional feature: define MEM_TIMEOUT_EN to abandon a memory wait after TIMEOUT cycles and
// pulse memErr.
module mem_stage #(
    parameter int unsigned N       = 24,
    parameter int unsigned BW      = 64,
    parameter int unsigned WBW     = 30,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           en,
    input  logic [BW-1:0]  bufferIn,
    input  logic           inValid,
    input  logic [N-1:0]   memRdata,
    input  logic           memAck,
    output logic           memReq,
    output logic           memWe,
    output logic [N-1:0]   memAddr,
    output logic [N-1:0]   memWdata,
    output logic           stall,
    output logic           branchTaken,
    output logic [N-1:0]   branchTarget,
    output logic [WBW-1:0] wbBuffer,
    output logic           memErr
);

    typedef enum logic {StIdle, StWait} state_e;

    state_e r_state;
    state_e w_state_next;

    // Execute-stage buffer fields
    logic [N-1:0] w_rd3;
    logic [3:0]   w_rc;
    logic         w_reg_write;
    logic         w_mem_to_reg;
    logic         w_mem_write;
    logic         w_branch_flag;
    logic         w_neg_flag;
    logic         w_zero_flag;
    logic [N-1:0] w_alu_result;
    logic         w_opcode0;
    logic         w_unused;

    assign w_rd3         = bufferIn[23:0];
    assign w_rc          = bufferIn[27:24];
    assign w_reg_write   = bufferIn[28];
    assign w_mem_to_reg  = bufferIn[29];
    assign w_mem_write   = bufferIn[30];
    assign w_branch_flag = bufferIn[31];
    assign w_neg_flag    = bufferIn[32];
    assign w_zero_flag   = bufferIn[33];
    assign w_alu_result  = bufferIn[57:34];
    assign w_opcode0     = bufferIn[58];
    // Upper opCode bits and opType are not needed by this stage
    assign w_unused      = ^bufferIn[BW-1:59];

    logic w_capture;
    logic w_is_mem;
    logic w_branch;
    logic w_timeout;

    assign w_capture = en && (r_state == StIdle) && inValid;
    assign w_is_mem  = w_mem_to_reg || w_mem_write;
    assign w_branch  = w_branch_flag && (w_opcode0 ? w_neg_flag : w_zero_flag);

    // Pending memory instruction context, needed to form the writeback on completion
    logic [3:0]   r_pend_rc;
    logic         r_pend_rw;
    logic         r_pend_store;
    logic [N-1:0] r_pend_alu;

    // Registered outputs
    logic         r_mem_req;
    logic         r_mem_we;
    logic [N-1:0] r_mem_addr;
    logic [N-1:0] r_mem_wdata;
    logic         r_branch_taken;
    logic [N-1:0] r_branch_target;
    logic [N-1:0] r_wb_result;
    logic [3:0]   r_wb_rc;
    logic         r_wb_rw;
    logic         r_wb_valid;

`ifdef MEM_TIMEOUT_EN
    localparam int unsigned CntW = $clog2(TIMEOUT + 1);

    logic [CntW-1:0] r_tmo_cnt;
    logic            r_mem_err;

    // A memAck on the same edge as the limit wins over the timeout
    assign w_timeout = (r_state == StWait) && !memAck && (r_tmo_cnt == CntW'(TIMEOUT - 1));

    // Wait-cycle counter: cleared on WAIT entry, counts enabled WAIT cycles
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tmo_cnt <= '0;
        end else if (en) begin
            if (w_capture && w_is_mem) begin
                r_tmo_cnt <= '0;
            end else if (r_state == StWait) begin
                r_tmo_cnt <= r_tmo_cnt + CntW'(1);
            end
        end
    end

    // Error pulse: high for the one enabled cycle following a timeout
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mem_err <= 1'b0;
        end else if (en) begin
            r_mem_err <= w_timeout;
        end
    end

    assign memErr = r_mem_err;
`else
    assign w_timeout = 1'b0;
    assign memErr    = 1'b0;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= StIdle;
        end else if (en) begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle: if (w_capture && w_is_mem) w_state_next = StWait;
            StWait: if (memAck || w_timeout) w_state_next = StIdle;
            default: w_state_next = StIdle;
        endcase
    end

    // Datapath: capture, memory request, writeback and branch redirect
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mem_req       <= 1'b0;
            r_mem_we        <= 1'b0;
            r_mem_addr      <= '0;
            r_mem_wdata     <= '0;
            r_branch_taken  <= 1'b0;
            r_branch_target <= '0;
            r_wb_result     <= '0;
            r_wb_rc         <= '0;
            r_wb_rw         <= 1'b0;
            r_wb_valid      <= 1'b0;
            r_pend_rc       <= '0;
            r_pend_rw       <= 1'b0;
            r_pend_store    <= 1'b0;
            r_pend_alu      <= '0;
        end else if (en) begin
            r_branch_taken <= 1'b0;
            r_wb_valid     <= 1'b0;
            if (w_capture) begin
                r_branch_taken <= w_branch;
                if (w_branch) begin
                    r_branch_target <= w_alu_result;
                end
                if (w_is_mem) begin
                    r_mem_req    <= 1'b1;
                    r_mem_we     <= w_mem_write;
                    r_mem_addr   <= w_alu_result;
                    r_mem_wdata  <= w_rd3;
                    r_pend_rc    <= w_rc;
                    // A store never writes the register file, even with memToReg set
                    r_pend_rw    <= w_reg_write && !w_mem_write;
                    r_pend_store <= w_mem_write;
                    r_pend_alu   <= w_alu_result;
                end else begin
                    r_wb_valid  <= 1'b1;
                    r_wb_rw     <= w_reg_write;
                    r_wb_rc     <= w_rc;
                    r_wb_result <= w_alu_result;
                end
            end else if (r_state == StWait) begin
                if (memAck) begin
                    r_mem_req   <= 1'b0;
                    r_mem_we    <= 1'b0;
                    r_wb_valid  <= 1'b1;
                    r_wb_rw     <= r_pend_rw;
                    r_wb_rc     <= r_pend_rc;
                    r_wb_result <= r_pend_store ? r_pend_alu : memRdata;
                end else if (w_timeout) begin
                    r_mem_req   <= 1'b0;
                    r_mem_we    <= 1'b0;
                    r_wb_valid  <= 1'b1;
                    r_wb_rw     <= 1'b0;
                    r_wb_rc     <= r_pend_rc;
                    r_wb_result <= r_pend_alu;
                end
            end
        end
    end

    assign memReq       = r_mem_req;
    assign memWe        = r_mem_we;
    assign memAddr      = r_mem_addr;
    assign memWdata     = r_mem_wdata;
    assign branchTaken  = r_branch_taken;
    assign branchTarget = r_branch_target;

    // Output decode: stall and writeback buffer packing
    always_comb begin
        stall                = (r_state == StWait);
        wbBuffer             = '0;
        wbBuffer[N-1:0]      = r_wb_result;
        wbBuffer[N+3:N]      = r_wb_rc;
        wbBuffer[N+4]        = r_wb_rw;
        wbBuffer[N+5]        = r_wb_valid;
    end

endmodule

// File: tb/tb_mem_stage.sv
// Testbench for mem_stage: directed scenarios followed by randomized traffic checked against a
// transaction-level model through a writeback/branch scoreboard.
// Define MEM_TIMEOUT_EN to also exercise the memory timeout.
module tb_mem_stage;

    localparam int unsigned N       = 24;
    localparam int unsigned BW      = 64;
    localparam int unsigned WBW     = 30;
    localparam int unsigned TIMEOUT = 16;

    logic           clk = 1'b0;
    logic           rst, en, inValid, memAck;
    logic [BW-1:0]  bufferIn;
    logic [N-1:0]   memRdata;
    logic           memReq, memWe, stall, branchTaken, memErr;
    logic [N-1:0]   memAddr, memWdata, branchTarget;
    logic [WBW-1:0] wbBuffer;

    mem_stage #(.N(N), .BW(BW), .WBW(WBW), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst), .en(en), .bufferIn(bufferIn), .inValid(inValid),
        .memRdata(memRdata), .memAck(memAck), .memReq(memReq), .memWe(memWe),
        .memAddr(memAddr), .memWdata(memWdata), .stall(stall), .branchTaken(branchTaken),
        .branchTarget(branchTarget), .wbBuffer(wbBuffer), .memErr(memErr)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] mk(input logic [23:0] rd3, input logic [3:0] rc,
                                       input logic rw, input logic m2r, input logic mw,
                                       input logic bf, input logic neg, input logic zero,
                                       input logic [23:0] alu, input logic [3:0] opc);
        return {2'b00, opc, alu, zero, neg, bf, mw, m2r, rw, rc, rd3};
    endfunction

    function automatic logic [29:0] wb(input logic rw, input logic [3:0] rc,
                                       input logic [23:0] res);
        return {1'b1, rw, rc, res};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard
    typedef struct {
        logic [29:0] val;
        bit          full;  // 0: result field not defined (timeout), compare control bits only
    } wb_exp_t;

    wb_exp_t     wq[$];
    logic [23:0] bq[$];
    bit          mon_on = 1'b0;

    // Monitor: a new writeback or redirect appears after every enabled, non-reset edge
    initial begin
        logic en_s, rst_s;
        wb_exp_t e;
        logic [23:0] t;
        forever begin
            @(posedge clk);
            en_s  = en;
            rst_s = rst;
            #1;
            if (mon_on && en_s && !rst_s) begin
                if (wbBuffer[29]) begin
                    if (wq.size() == 0) begin
                        chk("wb_unexpected", 32'(wbBuffer), 32'h0);
                    end else begin
                        e = wq.pop_front();
                        if (e.full) chk("wb_data", 32'(wbBuffer), 32'(e.val));
                        else chk("wb_ctrl", 32'(wbBuffer[29:24]), 32'(e.val[29:24]));
                    end
                end
                if (branchTaken) begin
                    if (bq.size() == 0) begin
                        chk("branch_unexpected", 32'(branchTarget), 32'h0);
                    end else begin
                        t = bq.pop_front();
                        chk("branch_target", 32'(branchTarget), 32'(t));
                    end
                end
            end
        end
    end

    // Transaction-level model of the stage
    bit          have_instr = 1'b0;
    logic [63:0] cur;
    bit          m_wait = 1'b0;
    bit          m_err = 1'b0;
    int          m_wait_cnt, m_ack_delay;
    logic [23:0] m_rdata, m_addr, m_wdata, m_alu;
    logic [3:0]  m_rc;
    bit          m_we, m_rw;

    task automatic cycle(input bit gen);
        logic [23:0] alu, rd3;
        logic [3:0]  rc;
        int          kind;
        logic        rw, m2r, mw, bf, neg, zero, taken;
        logic [3:0]  opc;
        @(negedge clk);
        en = ($urandom_range(0, 7) != 0);
        if (!have_instr && gen && ($urandom_range(0, 3) != 0)) begin
            kind = $urandom_range(0, 2);
            m2r  = (kind == 1) || ((kind == 2) && $urandom_range(0, 1) == 1);
            mw   = (kind == 2);
            bf   = ($urandom_range(0, 3) == 0);
            cur  = mk(24'($urandom), 4'($urandom), 1'($urandom), m2r, mw, bf,
                      1'($urandom), 1'($urandom), 24'($urandom), 4'($urandom));
            have_instr = 1'b1;
        end
        inValid  = have_instr;
        bufferIn = have_instr ? cur : 64'($urandom);
        memRdata = 24'($urandom);
        if (m_wait) begin
            memAck = (m_wait_cnt >= m_ack_delay);
            if (memAck) memRdata = m_rdata;
        end else begin
            memAck = ($urandom_range(0, 3) == 0);  // stray acks while idle
        end
        @(posedge clk);
        if (en) begin
            m_err = 1'b0;
            if (m_wait) begin
                if (memAck) begin
                    wq.push_back('{wb(m_rw, m_rc, m_we ? m_alu : m_rdata), 1'b1});
                    m_wait = 1'b0;
                end else begin
                    m_wait_cnt++;
`ifdef MEM_TIMEOUT_EN
                    if (m_wait_cnt == TIMEOUT) begin
                        wq.push_back('{wb(1'b0, m_rc, 24'h0), 1'b0});
                        m_wait = 1'b0;
                        m_err  = 1'b1;
                    end
`endif
                end
            end else if (inValid) begin
                {opc, alu, zero, neg, bf, mw, m2r, rw, rc, rd3} = cur[61:0];
                have_instr = 1'b0;
                taken = bf && (opc[0] ? neg : zero);
                if (taken) bq.push_back(alu);
                if (m2r || mw) begin
                    m_wait      = 1'b1;
                    m_wait_cnt  = 0;
                    m_ack_delay = $urandom_range(0, 5);
`ifdef MEM_TIMEOUT_EN
                    if ($urandom_range(0, 5) == 0) m_ack_delay = TIMEOUT + 4;
`endif
                    m_rdata = 24'($urandom);
                    m_addr  = alu;
                    m_wdata = rd3;
                    m_we    = mw;
                    m_rw    = rw && !mw;
                    m_rc    = rc;
                    m_alu   = alu;
                end else begin
                    wq.push_back('{wb(rw, rc, alu), 1'b1});
                end
            end
        end
        #1;
        chk("stall", 32'(stall), 32'(m_wait));
        chk("memReq", 32'(memReq), 32'(m_wait));
        chk("memErr", 32'(memErr), 32'(m_err));
        if (m_wait) begin
            chk("memAddr", 32'(memAddr), 32'(m_addr));
            chk("memWdata", 32'(memWdata), 32'(m_wdata));
            chk("memWe", 32'(memWe), 32'(m_we));
        end
    endtask

    initial begin
        int guard;
        rst = 1'b1; en = 1'b1; inValid = 1'b1; memAck = 1'b1;
        bufferIn = 64'hFFFF_FFFF_FFFF_FFFF; memRdata = '1;
        step();
        step();
        // Reset state
        chk("rst_memReq", 32'(memReq), 0);
        chk("rst_memWe", 32'(memWe), 0);
        chk("rst_memAddr", 32'(memAddr), 0);
        chk("rst_memWdata", 32'(memWdata), 0);
        chk("rst_wbBuffer", 32'(wbBuffer), 0);
        chk("rst_branchTaken", 32'(branchTaken), 0);
        chk("rst_branchTarget", 32'(branchTarget), 0);
        chk("rst_memErr", 32'(memErr), 0);
        chk("rst_stall", 32'(stall), 0);
        rst = 1'b0; memAck = 1'b0; inValid = 1'b0;

        // ALU op writes back one edge after capture
        bufferIn = mk(24'h0, 4'd3, 1, 0, 0, 0, 0, 0, 24'd4, 4'd0); inValid = 1'b1;
        step();
        chk("alu_wb", 32'(wbBuffer), 32'(wb(1'b1, 4'd3, 24'd4)));
        chk("alu_stall", 32'(stall), 0);

        // Load acknowledged on the third WAIT edge
        bufferIn = mk(24'h0, 4'd5, 1, 1, 0, 0, 0, 0, 24'h10, 4'd0);
        step();
        inValid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("load_stall", 32'(stall), 1);
            chk("load_memReq", 32'(memReq), 1);
            chk("load_memAddr", 32'(memAddr), 32'h10);
            chk("load_memWe", 32'(memWe), 0);
            if (i == 2) begin
                memAck = 1'b1; memRdata = 24'h55;
            end
            step();
        end
        memAck = 1'b0;
        chk("load_wb", 32'(wbBuffer), 32'(wb(1'b1, 4'd5, 24'h55)));
        chk("load_done_stall", 32'(stall), 0);
        chk("load_done_memReq", 32'(memReq), 0);

        // memToReg+memWrite is a store
        bufferIn = mk(24'd7, 4'd2, 1, 1, 1, 0, 0, 0, 24'd8, 4'd0); inValid = 1'b1;
        step();
        inValid = 1'b0;
        chk("store_memWe", 32'(memWe), 1);
        chk("store_memAddr", 32'(memAddr), 8);
        chk("store_memWdata", 32'(memWdata), 7);
        memAck = 1'b1;
        step();
        memAck = 1'b0;
        chk("store_wb", 32'(wbBuffer), 32'(wb(1'b0, 4'd2, 24'd8)));

        // Branch conditions
        bufferIn = mk(24'h0, 4'd0, 0, 0, 0, 1, 1, 0, 24'd12, 4'd1); inValid = 1'b1;
        step();
        chk("br_taken", 32'(branchTaken), 1);
        chk("br_target", 32'(branchTarget), 12);
        bufferIn = mk(24'h0, 4'd0, 0, 0, 0, 1, 0, 1, 24'd20, 4'd1);
        step();
        chk("br_not_taken", 32'(branchTaken), 0);
        chk("br_target_hold", 32'(branchTarget), 12);
        inValid = 1'b0;
        step();
        chk("idle_br_clear", 32'(branchTaken), 0);
        chk("idle_wb_clear", 32'(wbBuffer[29]), 0);

        // Reset while waiting abandons the request
        bufferIn = mk(24'h0, 4'd1, 1, 1, 0, 0, 0, 0, 24'h30, 4'd0); inValid = 1'b1;
        step();
        inValid = 1'b0;
        chk("wait_before_rst", 32'(stall), 1);
        rst = 1'b1; memAck = 1'b1;
        step();
        rst = 1'b0; memAck = 1'b0;
        chk("rstwait_memReq", 32'(memReq), 0);
        chk("rstwait_stall", 32'(stall), 0);
        chk("rstwait_wb", 32'(wbBuffer), 0);

`ifdef MEM_TIMEOUT_EN
        bufferIn = mk(24'h0, 4'd6, 1, 1, 0, 0, 0, 0, 24'h40, 4'd0); inValid = 1'b1;
        step();
        inValid = 1'b0;
        for (int i = 1; i < TIMEOUT; i++) begin
            step();
            chk("tmo_early_err", 32'(memErr), 0);
            chk("tmo_early_stall", 32'(stall), 1);
        end
        step();
        chk("tmo_err", 32'(memErr), 1);
        chk("tmo_stall", 32'(stall), 0);
        chk("tmo_memReq", 32'(memReq), 0);
        chk("tmo_wb_ctrl", 32'(wbBuffer[29:24]), 32'({1'b1, 1'b0, 4'd6}));
        step();
        chk("tmo_err_pulse", 32'(memErr), 0);
`endif

        // Randomized traffic against the model
        mon_on = 1'b1;
        for (int i = 0; i < 3000; i++) cycle(1'b1);
        guard = 0;
        while ((m_wait || have_instr) && guard < 500) begin
            cycle(1'b0);
            guard++;
        end
        chk("drain_timeout", 32'(m_wait || have_instr), 0);
        for (int i = 0; i < 4; i++) cycle(1'b0);
        chk("wb_queue_empty", 32'(wq.size()), 0);
        chk("branch_queue_empty", 32'(bq.size()), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 Parameters SHALL be: N, default 24, datapath width; BW, default 64, input buffer width; WBW, default 30, output buffer width; TIMEOUT, default 16, memory wait limit in cycles.
REQ-002 clk  input  1  rising-edge clock.
REQ-003 rst  input  1  synchronous active-high reset.
REQ-004 en  input  1  stage enable; when low, all state and outputs hold.
REQ-005 bufferIn  input  BW  execute-stage buffer: [23:0] rd3, [27:24] Rc, [28] regWrite, [29] memToReg, [30] memWrite, [31] branchFlag, [32] negFlag, [33] zeroFlag, [57:34] aluResult, [61:58] opCode, [63:62] opType.
REQ-006 inValid  input  1  bufferIn holds a live instruction.
REQ-007 memRdata  input  N  data-memory read data, valid with memAck.
REQ-008 memAck  input  1  data memory completes the current request.
REQ-009 memReq, memWe  output  1 each  memory request strobe and write select.
REQ-010 memAddr, memWdata  output  N each  memory address and store data.
REQ-011 stall  output  1  upstream holds bufferIn and inValid while high.
REQ-012 branchTaken  output  1; branchTarget  output  N  registered branch redirect.
REQ-013 wbBuffer  output  WBW  [23:0] result, [27:24] Rc, [28] regWrite, [29] valid.
REQ-014 memErr  output  1  one-cycle pulse on memory timeout.

Function
REQ-015 The FSM SHALL have states IDLE and WAIT; stall SHALL equal (state == WAIT).
REQ-016 In IDLE with en and inValid, the instruction SHALL be captured on that edge; it is a memory op if memToReg or memWrite is set.
REQ-017 Non-memory op: wbBuffer SHALL load {valid=1, regWrite, Rc, result=aluResult} on the capture edge (latency 1); state stays IDLE.
REQ-018 Memory op: on the capture edge state SHALL go WAIT, memReq=1, memAddr=aluResult, memWdata=rd3, memWe=memWrite; wbBuffer valid=0.
REQ-019 memWrite and memToReg both set SHALL be treated as a store (memWe=1, regWrite forced 0).
REQ-020 In WAIT, memReq, memAddr, memWdata, memWe SHALL hold stable until the edge on which memAck is sampled high.
REQ-021 On memAck in WAIT: state IDLE, memReq=0, wbBuffer = {valid=1, regWrite (0 for store), Rc, result = memRdata for load, aluResult for store}.
REQ-022 memAck while IDLE SHALL be ignored.
REQ-023 Instructions presented while stall is high SHALL NOT be captured; the held instruction is captured in the first IDLE cycle.
REQ-024 branchTaken SHALL register branchFlag AND (opCode[0] ? negFlag : zeroFlag) on each capture edge, else 0; branchTarget SHALL register aluResult when branchTaken is set.
REQ-025 IDLE with no capture SHALL clear wbBuffer valid and branchTaken on the next enabled edge.
REQ-026 en low SHALL freeze FSM, counter and all outputs, including during WAIT.

Reset
REQ-027 rst SHALL force on the next edge: state IDLE, memReq=0, memWe=0, memAddr=0, memWdata=0, wbBuffer=0, branchTaken=0, branchTarget=0, memErr=0, timeout counter 0.
REQ-028 rst SHALL take priority over en and memAck; reset during WAIT abandons the request without writeback.

Configuration
REQ-029 With MEM_TIMEOUT_EN defined, a counter SHALL clear on WAIT entry and increment each enabled WAIT cycle; at TIMEOUT cycles without memAck: state IDLE, memReq=0, memErr=1 for one cycle, wbBuffer {valid=1, regWrite=0}.
REQ-030 Without MEM_TIMEOUT_EN, WAIT SHALL persist until memAck, memErr SHALL be constant 0, and no counter SHALL be synthesized.

Verification
REQ-031 ALU op aluResult=4, Rc=3, regWrite=1 -> next edge wbBuffer result=4, Rc=3, regWrite=1, valid=1; stall=0.
REQ-032 Load aluResult=0x10, memAck after 3 cycles with memRdata=0x55 -> memReq/memAddr=0x10 held 3 cycles, stall high 3 cycles, wbBuffer result=0x55 valid=1.
REQ-033 Store aluResult=8, rd3=7, memToReg=1 also set -> memWe=1, memAddr=8, memWdata=7, wbBuffer regWrite=0.
REQ-034 branchFlag=1, opCode=1, negFlag=1, aluResult=12 -> branchTaken=1, branchTarget=12; with zeroFlag only and opCode=1 -> branchTaken=0.
REQ-035 rst asserted in WAIT -> next edge memReq=0, stall=0, wbBuffer=0; with MEM_TIMEOUT_EN, no memAck for 16 cycles -> memErr pulse, wbBuffer regWrite=0.
